ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DSize, default 32, data/address width.
REQ-002 Parameter RSize, default 5, register-index width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset; single clock domain.
REQ-005 ex_valid  input  1  EX slot holds a live instruction.
REQ-006 ex_kill  input  1  hazard-unit squash of the EX slot.
REQ-007 ex_alu_result  input  DSize  ALU result.
REQ-008 ex_overflow  input  1  ALU overflow.
REQ-009 ex_branch_true  input  1  ALU branch/jump taken.
REQ-010 ex_target  input  DSize  branch/jump target PC.
REQ-011 ex_pc  input  DSize  PC of EX instruction.
REQ-012 ex_rd, ex_reg_we, ex_mem_re, ex_mem_we  input  RSize/1/1/1  destination and control.
REQ-013 ex_store_data  input  DSize  store data.
REQ-014 stall  input  1  MEM stage busy; hold all state.
REQ-015 exc_clr  input  1  clear sticky overflow exception.
REQ-016 mem_valid, mem_alu_result, mem_rd, mem_reg_we, mem_mem_re, mem_mem_we, mem_store_data  output  registered copies (1/DSize/RSize/1/1/1/DSize).
REQ-017 redirect  output  1  one-cycle fetch-redirect request.
REQ-018 redirect_pc  output  DSize  target accompanying redirect.
REQ-019 exc_flag  output  1  sticky overflow exception.
REQ-020 exc_pc  output  DSize  PC of first overflowing instruction.
REQ-021 fwd_valid, fwd_rd, fwd_data  output  1/RSize/DSize  forwarding source = mem_valid & mem_reg_we, mem_rd, mem_alu_result.

Function
REQ-022 On rising edge with stall=0, all mem_* registers SHALL load from ex_*; mem_valid SHALL load ex_valid & ~ex_kill & ~redirect.
REQ-023 With stall=1, every register SHALL hold, including mem_valid.
REQ-024 Captured instruction with ex_overflow=1 SHALL have mem_reg_we and mem_mem_we forced 0 (write cancelled).
REQ-025 redirect SHALL equal mem_valid & mem_branch & ~redirect_done, where mem_branch and mem_target are registered ex_branch_true and ex_target; redirect_pc = mem_target.
REQ-026 redirect_done SHALL set on a cycle with redirect=1 and stall=1, and clear on any capture; redirect fires exactly once per taken branch regardless of stall length.
REQ-027 Latency: ALU result to mem_* and fwd_* is 1 cycle; taken branch to redirect is 1 cycle.
REQ-028 When a valid, unkilled instruction with ex_overflow=1 is captured, exc_flag SHALL set; exc_pc SHALL load ex_pc only if exc_flag was 0 (first wins).
REQ-029 exc_clr SHALL clear exc_flag next edge; simultaneous new overflow capture and exc_clr: set wins and exc_pc loads the new PC.
REQ-030 Invalid (mem_valid=0) slots SHALL never assert redirect, fwd_valid or exception.
REQ-031 No arithmetic beyond pass-through; all widths exact, no truncation.

Reset
REQ-032 rst low SHALL asynchronously clear all registers: mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, redirect_done, exc_flag = 0; all data/PC/rd registers = 0.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL drop redirect and fwd_valid immediately; first capture after release behaves per REQ-022.

Structure
REQ-034 DSize/RSize defaults and an ex_mem_t packed struct of the captured fields SHALL live in a shared pipeline package.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 Capture: ex_valid=1, alu_result=0x0000_1234, rd=3, reg_we=1 -> next cycle mem_alu_result=0x1234, fwd_valid=1, fwd_rd=3.
REQ-037 Branch: ex_branch_true=1, ex_target=0x100 -> next cycle redirect=1, redirect_pc=0x100; following EX instruction captured with mem_valid=0.
REQ-038 Branch + 3-cycle stall -> redirect high exactly 1 cycle, mem_* held throughout.
REQ-039 Overflow: 0x7FFF_FFFF+1 with ex_overflow=1, ex_pc=0x40 -> mem_reg_we=0, exc_flag=1, exc_pc=0x40; second overflow at 0x44 keeps exc_pc=0x40.
REQ-040 exc_clr coincident with overflow at 0x48 -> exc_flag=1, exc_pc=0x48.
REQ-041 ex_kill=1 with branch_true=1 -> mem_valid=0, no redirect; async rst mid-stall -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg -- shared pipeline definitions for the EX/MEM boundary.
//   DSIZE_DEF / RSIZE_DEF : default data/address and register-index widths.
//   ex_mem_t              : packed image of the fields captured at EX->MEM.
//   slot_live()           : an EX slot is really captured as live.
//   write_keep()          : a write enable that survives an ALU overflow.
package ex_mem_reg_pkg;

    localparam int DSIZE_DEF = 32;
    localparam int RSIZE_DEF = 5;

    typedef struct packed {
        logic                 valid;
        logic [DSIZE_DEF-1:0] alu_result;
        logic [RSIZE_DEF-1:0] rd;
        logic                 reg_we;
        logic                 mem_re;
        logic                 mem_we;
        logic [DSIZE_DEF-1:0] store_data;
        logic                 branch;
        logic [DSIZE_DEF-1:0] target;
    } ex_mem_t;

    // A slot is live when it holds an instruction, the hazard unit did not
    // squash it, and it is not the wrong-path instruction behind a redirect.
    function automatic logic slot_live(input logic valid,
                                       input logic kill,
                                       input logic redirect);
        return valid & ~kill & ~redirect;
    endfunction

    // An overflowing instruction must not commit its architectural writes.
    function automatic logic write_keep(input logic we,
                                        input logic overflow);
        return we & ~overflow;
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if -- bundle of EX-side inputs and MEM-side outputs around the
// EX/MEM pipeline register.
//   slave  : the pipeline register (consumes ex_*, stall, exc_clr; drives
//            mem_*, redirect*, exc_*, fwd_*).
//   master : the surrounding pipeline (the opposite directions).
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int DSize = DSIZE_DEF,
    parameter int RSize = RSIZE_DEF
);
    logic             ex_valid;
    logic             ex_kill;
    logic [DSize-1:0] ex_alu_result;
    logic             ex_overflow;
    logic             ex_branch_true;
    logic [DSize-1:0] ex_target;
    logic [DSize-1:0] ex_pc;
    logic [RSize-1:0] ex_rd;
    logic             ex_reg_we;
    logic             ex_mem_re;
    logic             ex_mem_we;
    logic [DSize-1:0] ex_store_data;
    logic             stall;
    logic             exc_clr;

    logic             mem_valid;
    logic [DSize-1:0] mem_alu_result;
    logic [RSize-1:0] mem_rd;
    logic             mem_reg_we;
    logic             mem_mem_re;
    logic             mem_mem_we;
    logic [DSize-1:0] mem_store_data;
    logic             redirect;
    logic [DSize-1:0] redirect_pc;
    logic             exc_flag;
    logic [DSize-1:0] exc_pc;
    logic             fwd_valid;
    logic [RSize-1:0] fwd_rd;
    logic [DSize-1:0] fwd_data;

    modport slave (
        input  ex_valid, ex_kill, ex_alu_result, ex_overflow, ex_branch_true,
               ex_target, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
               ex_store_data, stall, exc_clr,
        output mem_valid, mem_alu_result, mem_rd, mem_reg_we, mem_mem_re,
               mem_mem_we, mem_store_data, redirect, redirect_pc, exc_flag,
               exc_pc, fwd_valid, fwd_rd, fwd_data
    );

    modport master (
        output ex_valid, ex_kill, ex_alu_result, ex_overflow, ex_branch_true,
               ex_target, ex_pc, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
               ex_store_data, stall, exc_clr,
        input  mem_valid, mem_alu_result, mem_rd, mem_reg_we, mem_mem_re,
               mem_mem_we, mem_store_data, redirect, redirect_pc, exc_flag,
               exc_pc, fwd_valid, fwd_rd, fwd_data
    );

endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg -- EX/MEM pipeline register with branch redirect, overflow
// write-cancel, sticky overflow exception and MEM-stage forwarding source.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : ex_mem_reg_if.slave -- ex_* / stall / exc_clr in; mem_*,
//         redirect, redirect_pc, exc_flag, exc_pc, fwd_* out.
// redirect and fwd_valid are pure AND terms of registered state so that an
// asserted reset removes them without waiting for a clock edge.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DSize = DSIZE_DEF,
    parameter int RSize = RSIZE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ex_mem_reg_if.slave   bus
);

    logic             mem_valid_r;
    logic [DSize-1:0] mem_alu_result_r;
    logic [RSize-1:0] mem_rd_r;
    logic             mem_reg_we_r;
    logic             mem_mem_re_r;
    logic             mem_mem_we_r;
    logic [DSize-1:0] mem_store_data_r;
    logic             mem_branch_r;
    logic [DSize-1:0] mem_target_r;
    logic             redirect_done_r;
    logic             exc_flag_r;
    logic [DSize-1:0] exc_pc_r;

    logic             redirect_s;
    logic             live_s;
    logic             ovf_capture_s;

    // Derive redirect, slot liveness and the overflow-capture event.
    always_comb begin
        redirect_s    = 1'b0;
        live_s        = 1'b0;
        ovf_capture_s = 1'b0;
        redirect_s    = mem_valid_r & mem_branch_r & ~redirect_done_r;
        live_s        = slot_live(bus.ex_valid, bus.ex_kill, redirect_s);
        if (!bus.stall) begin
            ovf_capture_s = live_s & bus.ex_overflow;
        end else begin
            ovf_capture_s = 1'b0;
        end
    end

    // Pipeline capture and one-shot redirect bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_r      <= 1'b0;
            mem_alu_result_r <= '0;
            mem_rd_r         <= '0;
            mem_reg_we_r     <= 1'b0;
            mem_mem_re_r     <= 1'b0;
            mem_mem_we_r     <= 1'b0;
            mem_store_data_r <= '0;
            mem_branch_r     <= 1'b0;
            mem_target_r     <= '0;
            redirect_done_r  <= 1'b0;
        end else if (!bus.stall) begin
            mem_valid_r      <= live_s;
            mem_alu_result_r <= bus.ex_alu_result;
            mem_rd_r         <= bus.ex_rd;
            mem_reg_we_r     <= write_keep(bus.ex_reg_we, bus.ex_overflow);
            mem_mem_re_r     <= bus.ex_mem_re;
            mem_mem_we_r     <= write_keep(bus.ex_mem_we, bus.ex_overflow);
            mem_store_data_r <= bus.ex_store_data;
            mem_branch_r     <= bus.ex_branch_true;
            mem_target_r     <= bus.ex_target;
            redirect_done_r  <= 1'b0;
        end else if (redirect_s) begin
            // The redirect was presented while stalled; suppress repeats
            // until the branch leaves the stage.
            redirect_done_r  <= 1'b1;
        end else begin
            redirect_done_r  <= redirect_done_r;
        end
    end

    // Sticky overflow exception: first PC wins unless cleared in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_flag_r <= 1'b0;
            exc_pc_r   <= '0;
        end else if (bus.stall) begin
            exc_flag_r <= exc_flag_r;
            exc_pc_r   <= exc_pc_r;
        end else if (ovf_capture_s) begin
            exc_flag_r <= 1'b1;
            if (!exc_flag_r || bus.exc_clr) begin
                exc_pc_r <= bus.ex_pc;
            end else begin
                exc_pc_r <= exc_pc_r;
            end
        end else if (bus.exc_clr) begin
            exc_flag_r <= 1'b0;
            exc_pc_r   <= exc_pc_r;
        end else begin
            exc_flag_r <= exc_flag_r;
            exc_pc_r   <= exc_pc_r;
        end
    end

    assign bus.mem_valid      = mem_valid_r;
    assign bus.mem_alu_result = mem_alu_result_r;
    assign bus.mem_rd         = mem_rd_r;
    assign bus.mem_reg_we     = mem_reg_we_r;
    assign bus.mem_mem_re     = mem_mem_re_r;
    assign bus.mem_mem_we     = mem_mem_we_r;
    assign bus.mem_store_data = mem_store_data_r;
    assign bus.redirect       = redirect_s;
    assign bus.redirect_pc    = mem_target_r;
    assign bus.exc_flag       = exc_flag_r;
    assign bus.exc_pc         = exc_pc_r;
    assign bus.fwd_valid      = mem_valid_r & mem_reg_we_r;
    assign bus.fwd_rd         = mem_rd_r;
    assign bus.fwd_data       = mem_alu_result_r;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg -- directed self-checking bench for ex_mem_reg.
module tb_ex_mem_reg;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    ex_mem_reg_if #(.DSize(32), .RSize(5)) bus ();

    ex_mem_reg #(.DSize(32), .RSize(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report a mismatch.
    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample shortly after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Put an idle (bubble) instruction on the EX inputs.
    task automatic ex_idle();
        bus.ex_valid       = 1'b0;
        bus.ex_kill        = 1'b0;
        bus.ex_alu_result  = 32'h0;
        bus.ex_overflow    = 1'b0;
        bus.ex_branch_true = 1'b0;
        bus.ex_target      = 32'h0;
        bus.ex_pc          = 32'h0;
        bus.ex_rd          = 5'd0;
        bus.ex_reg_we      = 1'b0;
        bus.ex_mem_re      = 1'b0;
        bus.ex_mem_we      = 1'b0;
        bus.ex_store_data  = 32'h0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b0;
        ex_idle();
        bus.stall   = 1'b0;
        bus.exc_clr = 1'b0;
        #12;
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_redirect",  64'(bus.redirect),  64'd0);
        chk("rst_exc_flag",  64'(bus.exc_flag),  64'd0);
        chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        chk("rst_alu",       64'(bus.mem_alu_result), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Plain capture feeding the forwarding path.
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 32'h0000_1234;
        bus.ex_rd         = 5'd3;
        bus.ex_reg_we     = 1'b1;
        bus.ex_mem_re     = 1'b1;
        bus.ex_store_data = 32'h0000_00AA;
        step();
        chk("cap_alu",       64'(bus.mem_alu_result), 64'h1234);
        chk("cap_valid",     64'(bus.mem_valid), 64'd1);
        chk("cap_fwd_valid", 64'(bus.fwd_valid), 64'd1);
        chk("cap_fwd_rd",    64'(bus.fwd_rd), 64'd3);
        chk("cap_fwd_data",  64'(bus.fwd_data), 64'h1234);
        chk("cap_mem_re",    64'(bus.mem_mem_re), 64'd1);
        chk("cap_store",     64'(bus.mem_store_data), 64'hAA);
        chk("cap_redirect",  64'(bus.redirect), 64'd0);

        // Taken branch, then the wrong-path instruction behind it.
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_branch_true = 1'b1;
        bus.ex_target      = 32'h0000_0100;
        bus.ex_alu_result  = 32'h55;
        step();
        chk("br_redirect",    64'(bus.redirect), 64'd1);
        chk("br_redirect_pc", 64'(bus.redirect_pc), 64'h100);
        ex_idle();
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 32'h77;
        bus.ex_reg_we     = 1'b1;
        bus.ex_rd         = 5'd9;
        step();
        chk("br_next_valid", 64'(bus.mem_valid), 64'd0);
        chk("br_next_redir", 64'(bus.redirect), 64'd0);
        chk("br_next_fwd",   64'(bus.fwd_valid), 64'd0);
        chk("br_next_alu",   64'(bus.mem_alu_result), 64'h77);

        // Taken branch held by a 3-cycle stall: redirect exactly once.
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_branch_true = 1'b1;
        bus.ex_target      = 32'h0000_0200;
        bus.ex_alu_result  = 32'h99;
        step();
        chk("st_redirect0", 64'(bus.redirect), 64'd1);
        bus.stall          = 1'b1;
        bus.ex_alu_result  = 32'hDEAD;
        bus.ex_branch_true = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_redirect", 64'(bus.redirect), 64'd0);
            chk("st_hold_alu", 64'(bus.mem_alu_result), 64'h99);
            chk("st_hold_vld", 64'(bus.mem_valid), 64'd1);
            chk("st_hold_pc",  64'(bus.redirect_pc), 64'h200);
        end
        bus.stall = 1'b0;
        ex_idle();
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 32'h11;
        step();
        chk("st_release_vld", 64'(bus.mem_valid), 64'd1);
        chk("st_release_alu", 64'(bus.mem_alu_result), 64'h11);
        chk("st_release_red", 64'(bus.redirect), 64'd0);

        // Overflow: write cancelled, exception records the first PC.
        ex_idle();
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 32'h8000_0000;
        bus.ex_overflow   = 1'b1;
        bus.ex_pc         = 32'h40;
        bus.ex_reg_we     = 1'b1;
        bus.ex_mem_we     = 1'b1;
        bus.ex_rd         = 5'd4;
        step();
        chk("ov_reg_we",   64'(bus.mem_reg_we), 64'd0);
        chk("ov_mem_we",   64'(bus.mem_mem_we), 64'd0);
        chk("ov_fwd",      64'(bus.fwd_valid), 64'd0);
        chk("ov_exc_flag", 64'(bus.exc_flag), 64'd1);
        chk("ov_exc_pc",   64'(bus.exc_pc), 64'h40);
        bus.ex_pc = 32'h44;
        step();
        chk("ov2_exc_pc",  64'(bus.exc_pc), 64'h40);
        bus.ex_pc   = 32'h48;
        bus.exc_clr = 1'b1;
        step();
        chk("ovclr_flag",  64'(bus.exc_flag), 64'd1);
        chk("ovclr_pc",    64'(bus.exc_pc), 64'h48);
        ex_idle();
        bus.ex_valid = 1'b1;
        bus.ex_pc    = 32'h4C;
        step();
        chk("clr_flag",    64'(bus.exc_flag), 64'd0);
        chk("clr_pc_keep", 64'(bus.exc_pc), 64'h48);
        bus.exc_clr = 1'b0;

        // Killed branch: no capture, no redirect.
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_kill        = 1'b1;
        bus.ex_branch_true = 1'b1;
        bus.ex_target      = 32'h300;
        step();
        chk("kill_valid",    64'(bus.mem_valid), 64'd0);
        chk("kill_redirect", 64'(bus.redirect), 64'd0);

        // Overflow in an invalid slot raises nothing.
        ex_idle();
        bus.ex_overflow = 1'b1;
        bus.ex_pc       = 32'h60;
        step();
        chk("inv_exc_flag", 64'(bus.exc_flag), 64'd0);

        // Arm an exception, then a branch with a forwarded write, then reset
        // asynchronously in the middle of a stall.
        ex_idle();
        bus.ex_valid    = 1'b1;
        bus.ex_overflow = 1'b1;
        bus.ex_pc       = 32'h80;
        step();
        chk("pre_exc_flag", 64'(bus.exc_flag), 64'd1);
        ex_idle();
        bus.ex_valid       = 1'b1;
        bus.ex_branch_true = 1'b1;
        bus.ex_target      = 32'h400;
        bus.ex_reg_we      = 1'b1;
        bus.ex_rd          = 5'd7;
        bus.ex_alu_result  = 32'hCAFE;
        step();
        chk("pre_redirect", 64'(bus.redirect), 64'd1);
        chk("pre_fwd",      64'(bus.fwd_valid), 64'd1);
        bus.stall = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_redirect", 64'(bus.redirect), 64'd0);
        chk("arst_fwd",      64'(bus.fwd_valid), 64'd0);
        chk("arst_valid",    64'(bus.mem_valid), 64'd0);
        chk("arst_alu",      64'(bus.mem_alu_result), 64'd0);
        chk("arst_rpc",      64'(bus.redirect_pc), 64'd0);
        chk("arst_exc_flag", 64'(bus.exc_flag), 64'd0);
        chk("arst_exc_pc",   64'(bus.exc_pc), 64'd0);
        chk("arst_fwd_rd",   64'(bus.fwd_rd), 64'd0);
        @(negedge clk);
        rst       = 1'b1;
        bus.stall = 1'b0;
        ex_idle();
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = 32'h5;
        step();
        chk("post_valid", 64'(bus.mem_valid), 64'd1);
        chk("post_alu",   64'(bus.mem_alu_result), 64'h5);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
